// File: rtl/fp16_mul_collector.sv
// fp16_mul_collector
//   Sits behind a free-running fp16 multiplier that has neither a valid
//   signal nor a stall input. A tag line running in parallel with the
//   multiplier marks which results belong to real operand pairs. Those
//   results are captured into a result FIFO and presented on a ready/valid
//   port. in_ready is credit-based: an issue is accepted only when a FIFO
//   slot is reserved for its result, so the unstallable multiplier can never
//   produce a result that has nowhere to go.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   in_valid     upstream presents a real operand pair this cycle
//   in_ready     a result slot is reserved; in_fire = in_valid & in_ready
//   mul_out      multiplier result bus (fp16)
//   res_valid    FIFO head is valid
//   res_ready    consumer accepts the head; res_fire = res_valid & res_ready
//   res_data     FIFO head (fp16), 0 when the FIFO is empty
//   res_is_nan   head is a NaN
//   res_is_inf   head is +/- infinity
//   res_is_zero  head is +/- zero
//   fifo_count   entries currently held
//   err_overflow sticky: a capture arrived while the FIFO was full
module fp16_mul_collector #(
    parameter int MUL_LATENCY = 10,
    parameter int DEPTH       = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [15:0]                mul_out,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [15:0]                res_data,
    output logic                       res_is_nan,
    output logic                       res_is_inf,
    output logic                       res_is_zero,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic                       err_overflow
);

    localparam int DATA_W = 16;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH+1);

    logic [MUL_LATENCY-1:0] tag_p;
    logic [DATA_W-1:0]      mem [DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       credits;

    logic in_fire;
    logic res_fire;
    logic cap;
    logic full;
    logic wr_en;

    assign in_ready = (credits != '0) && !rst;
    assign in_fire  = in_valid & in_ready;
    assign res_fire = res_valid & res_ready;
    assign cap      = tag_p[MUL_LATENCY-1];
    assign full     = (fifo_count == CNT_W'(DEPTH));
    // A full FIFO can still take a capture when the head leaves on the same
    // edge: the slot being written is the one being read out.
    assign wr_en    = cap & (!full | res_fire);

    // ---- issue stage: tag line mirrors the multiplier pipeline ----
    // Shift form keeps this legal for any MUL_LATENCY >= 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_p <= '0;
        end else begin
            tag_p <= (tag_p << 1) | MUL_LATENCY'(in_fire);
        end
    end

    // ---- capture stage: result storage (data only, never reset) ----
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= mul_out;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count   <= '0;
            err_overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (res_fire) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_en, res_fire})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (cap && full && !res_fire) begin
                err_overflow <= 1'b1;
            end
        end
    end

    // Credits = DEPTH - fifo_count - results in flight. A slot is claimed at
    // issue and returned only when its result leaves the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credits <= CNT_W'(DEPTH);
        end else begin
            case ({in_fire, res_fire})
                2'b10:   credits <= credits - CNT_W'(1);
                2'b01:   credits <= credits + CNT_W'(1);
                default: credits <= credits;
            endcase
        end
    end

    // ---- output stage: first-word fall-through head and its decodes ----
    assign res_valid   = (fifo_count != '0);
    assign res_data    = res_valid ? mem[rd_ptr] : '0;
    assign res_is_nan  = (res_data[14:10] == 5'h1f) && (res_data[9:0] != 10'h0);
    assign res_is_inf  = (res_data[14:10] == 5'h1f) && (res_data[9:0] == 10'h0);
    assign res_is_zero = (res_data[14:0] == 15'h0);

endmodule

// File: tb/tb_fp16_mul_collector.sv
// Bench for fp16_mul_collector. A stand-in 10-stage multiplier delays a
// hand-computed product driven on mul_in; a lockstep model tracks tags,
// queued results and credits from the bench's own inputs.
module tb_fp16_mul_collector;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] mul_in = 16'hDEAD;
    logic [15:0] mul_out;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [15:0] res_data;
    logic        res_is_nan;
    logic        res_is_inf;
    logic        res_is_zero;
    logic [4:0]  fifo_count;
    logic        err_overflow;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Stand-in multiplier: free-running, unreset, 10 register stages.
    logic [15:0] mp [10];
    always @(posedge clk) begin
        mp[0] <= mul_in;
        for (int i = 1; i < 10; i++) mp[i] <= mp[i-1];
    end
    assign mul_out = mp[9];

    fp16_mul_collector #(.MUL_LATENCY(10), .DEPTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .mul_out(mul_out), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_is_nan(res_is_nan), .res_is_inf(res_is_inf),
        .res_is_zero(res_is_zero), .fifo_count(fifo_count),
        .err_overflow(err_overflow)
    );

    // Reference model state
    logic [9:0]  m_tag;
    logic [15:0] m_val [10];
    logic [15:0] q [$];
    int          m_count;
    int          m_credits;

    task automatic model_reset();
        m_tag = '0;
        q.delete();
        m_count = 0;
        m_credits = 16;
    endtask

    // One clock: inputs are already set (at the falling edge); returns at the
    // next falling edge with the model advanced.
    task automatic cycle();
        logic f, rf, c;
        logic [15:0] cv;
        f  = in_valid && (m_credits != 0);
        rf = res_ready && (m_count != 0);
        c  = m_tag[9];
        cv = m_val[9];
        @(posedge clk);
        if (rf) void'(q.pop_front());
        if (c) q.push_back(cv);
        m_count = q.size();
        m_credits = m_credits - (f ? 1 : 0) + (rf ? 1 : 0);
        for (int i = 9; i > 0; i--) m_val[i] = m_val[i-1];
        m_val[0] = mul_in;
        m_tag = {m_tag[8:0], f};
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        mul_in = 16'hDEAD;
        repeat (n) cycle();
    endtask

    task automatic test_reset();
        model_reset();
        #1;
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL reset_fifo_count: got %0d want 0", fifo_count); end
        checks++; if (res_data !== 16'h0) begin errors++; $display("FAIL reset_res_data: got %h want 0000", res_data); end
        checks++; if (err_overflow !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_overflow); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
        @(negedge clk);
    endtask

    task automatic test_single();
        int n;
        // a=3C00 (1.0) * b=4000 (2.0) = 4000 (2.0)
        in_valid = 1'b1;
        mul_in = 16'h4000;
        cycle();
        in_valid = 1'b0;
        mul_in = 16'hDEAD;
        n = 1;
        while (!res_valid && n < 40) begin
            cycle();
            n++;
        end
        checks++; if (n !== 11) begin errors++; $display("FAIL single_latency: got %0d edges want 11", n); end
        checks++; if (res_data !== 16'h4000) begin errors++; $display("FAIL single_data: got %h want 4000", res_data); end
        checks++; if ({res_is_nan, res_is_inf, res_is_zero} !== 3'b000) begin errors++; $display("FAIL single_flags: got %b want 000", {res_is_nan, res_is_inf, res_is_zero}); end
        res_ready = 1'b1;
        cycle();
        res_ready = 1'b0;
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL single_pop: got %b want 0", res_valid); end
    endtask

    task automatic test_fill();
        int fires;
        res_ready = 1'b0;
        fires = 0;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            mul_in = 16'h1000 + 16'(i);
            if (in_ready) fires++;
            cycle();
        end
        checks++; if (fires !== 16) begin errors++; $display("FAIL fill_fires: got %0d want 16", fires); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready: got %b want 0", in_ready); end
        idle(12);
        checks++; if (fifo_count !== 5'd16) begin errors++; $display("FAIL fill_count: got %0d want 16", fifo_count); end
        checks++; if (err_overflow !== 1'b0) begin errors++; $display("FAIL fill_err: got %b want 0", err_overflow); end
        res_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            checks++; if (res_data !== 16'h1000 + 16'(k)) begin errors++; $display("FAIL fill_order[%0d]: got %h want %h", k, res_data, 16'h1000 + 16'(k)); end
            cycle();
            if (k == 0) begin
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_credit_return: got %b want 1", in_ready); end
            end
        end
        res_ready = 1'b0;
        checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL fill_drained: got %0d want 0", fifo_count); end
    endtask

    task automatic test_simul();
        res_ready = 1'b0;
        for (int i = 0; i < 15; i++) begin
            in_valid = 1'b1;
            mul_in = 16'h2000 + 16'(i);
            cycle();
        end
        idle(12);
        checks++; if (fifo_count !== 5'd15) begin errors++; $display("FAIL simul_pre_count: got %0d want 15", fifo_count); end
        checks++; if (dut.credits !== 5'd1) begin errors++; $display("FAIL simul_pre_credits: got %0d want 1", dut.credits); end
        in_valid = 1'b1;
        res_ready = 1'b1;
        mul_in = 16'h2100;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL simul_ready_before: got %b want 1", in_ready); end
        cycle();
        in_valid = 1'b0;
        res_ready = 1'b0;
        mul_in = 16'hDEAD;
        checks++; if (dut.credits !== 5'd1) begin errors++; $display("FAIL simul_credits: got %0d want 1", dut.credits); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL simul_in_ready: got %b want 1", in_ready); end
        checks++; if (fifo_count !== 5'd14) begin errors++; $display("FAIL simul_count_after: got %0d want 14", fifo_count); end
        for (int i = 0; i < 10; i++) begin
            cycle();
            checks++; if (fifo_count !== 5'(m_count)) begin errors++; $display("FAIL simul_count[%0d]: got %0d want %0d", i, fifo_count, m_count); end
        end
        checks++; if (fifo_count !== 5'd15) begin errors++; $display("FAIL simul_final_count: got %0d want 15", fifo_count); end
        res_ready = 1'b1;
        for (int k = 0; k < 15; k++) begin
            checks++;
            if (res_data !== ((k < 14) ? 16'h2001 + 16'(k) : 16'h2100)) begin
                errors++;
                $display("FAIL simul_order[%0d]: got %h want %h", k, res_data, (k < 14) ? 16'h2001 + 16'(k) : 16'h2100);
            end
            cycle();
        end
        res_ready = 1'b0;
    endtask

    task automatic test_special();
        res_ready = 1'b0;
        in_valid = 1'b1;
        mul_in = 16'h7E00;  // 7C00 (+inf) * 0000 (+0)  -> NaN
        cycle();
        mul_in = 16'h7C00;  // 7C00 (+inf) * 3C00 (1.0) -> +inf
        cycle();
        mul_in = 16'h8000;  // 8000 (-0)   * 3C00 (1.0) -> -0
        cycle();
        idle(12);
        checks++; if (fifo_count !== 5'd3) begin errors++; $display("FAIL special_count: got %0d want 3", fifo_count); end
        res_ready = 1'b1;
        checks++; if ({res_data, res_is_nan, res_is_inf, res_is_zero} !== {16'h7E00, 3'b100}) begin errors++; $display("FAIL special_nan: got %h/%b want 7e00/100", res_data, {res_is_nan, res_is_inf, res_is_zero}); end
        cycle();
        checks++; if ({res_data, res_is_nan, res_is_inf, res_is_zero} !== {16'h7C00, 3'b010}) begin errors++; $display("FAIL special_inf: got %h/%b want 7c00/010", res_data, {res_is_nan, res_is_inf, res_is_zero}); end
        cycle();
        checks++; if ({res_data, res_is_nan, res_is_inf, res_is_zero} !== {16'h8000, 3'b001}) begin errors++; $display("FAIL special_zero: got %h/%b want 8000/001", res_data, {res_is_nan, res_is_inf, res_is_zero}); end
        cycle();
        res_ready = 1'b0;
    endtask

    task automatic test_rst_mid();
        int seen;
        res_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            mul_in = 16'h3000 + 16'(i);
            cycle();
        end
        idle(5);
        checks++; if (fifo_count !== 5'd3) begin errors++; $display("FAIL rstmid_pre_count: got %0d want 3", fifo_count); end
        rst = 1'b1;
        #1;
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rstmid_res_valid: got %b want 0", res_valid); end
        checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL rstmid_count: got %0d want 0", fifo_count); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_in_ready: got %b want 0", in_ready); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_release_ready: got %b want 1", in_ready); end
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (res_valid) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rstmid_stale: got %0d valid cycles want 0", seen); end
        checks++; if (dut.credits !== 5'd16) begin errors++; $display("FAIL rstmid_credits: got %0d want 16", dut.credits); end
    endtask

    task automatic test_drop();
        res_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            mul_in = 16'h5000 + 16'(i);
            cycle();
        end
        idle(12);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL drop_in_ready: got %b want 0", in_ready); end
        in_valid = 1'b1;
        mul_in = 16'h4400;  // 4000 (2.0) * 4000 (2.0) = 4400 (4.0), must be discarded
        repeat (3) cycle();
        idle(12);
        checks++; if (fifo_count !== 5'd16) begin errors++; $display("FAIL drop_count: got %0d want 16", fifo_count); end
        checks++; if (dut.credits !== 5'd0) begin errors++; $display("FAIL drop_credits: got %0d want 0", dut.credits); end
        checks++; if (err_overflow !== 1'b0) begin errors++; $display("FAIL drop_err: got %b want 0", err_overflow); end
        res_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            checks++; if (res_data !== 16'h5000 + 16'(k)) begin errors++; $display("FAIL drop_order[%0d]: got %h want %h", k, res_data, 16'h5000 + 16'(k)); end
            cycle();
        end
        res_ready = 1'b0;
        checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL drop_drained: got %0d want 0", fifo_count); end
        checks++; if (dut.credits !== 5'd16) begin errors++; $display("FAIL drop_credits_back: got %0d want 16", dut.credits); end
    endtask

    task automatic test_soak();
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            res_ready = ($urandom_range(0, 2) == 0);
            mul_in    = 16'($urandom);
            checks++; if (in_ready !== (m_credits != 0)) begin errors++; $display("FAIL soak_in_ready[%0d]: got %b want %b", i, in_ready, m_credits != 0); end
            checks++; if (fifo_count !== 5'(m_count)) begin errors++; $display("FAIL soak_count[%0d]: got %0d want %0d", i, fifo_count, m_count); end
            checks++; if (dut.credits !== 5'(m_credits)) begin errors++; $display("FAIL soak_credits[%0d]: got %0d want %0d", i, dut.credits, m_credits); end
            if (m_count != 0) begin
                checks++; if (res_data !== q[0]) begin errors++; $display("FAIL soak_data[%0d]: got %h want %h", i, res_data, q[0]); end
            end
            cycle();
        end
        in_valid = 1'b0;
        res_ready = 1'b1;
        repeat (30) cycle();
        res_ready = 1'b0;
        checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL soak_drained: got %0d want 0", fifo_count); end
        checks++; if (dut.credits !== 5'd16) begin errors++; $display("FAIL soak_credits_end: got %0d want 16", dut.credits); end
        checks++; if (err_overflow !== 1'b0) begin errors++; $display("FAIL soak_err: got %b want 0", err_overflow); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_simul();
        test_special();
        test_rst_mid();
        test_drop();
        test_soak();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
